seq_det_grp: RTL

Parametrised serial pattern detector with a grouped match counter. Samples one bit per valid cycle and flags each occurrence of a compile-time pattern on `Z1`. Counts matches and flags every `TARGET`-th match on `Z2`. Supersedes the fixed 4-bit detector, counter and decoder chain. Adds a configurable pattern, overlap mode, input qualifier, soft clear and a count readout; everything runs on one clock.

---
 rtl/seq_det_grp_if.sv | 34 +++
 rtl/seq_det_grp.sv | 118 +++++++++++
 2 files changed

// File: rtl/seq_det_grp_if.sv
// Serial-in / pulse-out port bundle for seq_det_grp.
// TOTAL exists only when SEQ_DET_GRP_TOTAL_EN is defined.
interface seq_det_grp_if #(
    parameter int CNT_W = 3
);
    // X is taken on every rising edge where X_VLD is high. There is no
    // backpressure: the detector accepts a bit every valid cycle, and
    // Z1/Z2 are single-cycle pulses with no acknowledge.
    logic             X;
    logic             X_VLD;
    logic             CLR;
    logic             Z1;
    logic             Z2;
    logic [CNT_W-1:0] CNT;
`ifdef SEQ_DET_GRP_TOTAL_EN
    logic [15:0]      TOTAL;
`endif

    modport master (
        output X, X_VLD, CLR,
`ifdef SEQ_DET_GRP_TOTAL_EN
        input  TOTAL,
`endif
        input  Z1, Z2, CNT
    );

    modport slave (
        input  X, X_VLD, CLR,
`ifdef SEQ_DET_GRP_TOTAL_EN
        output TOTAL,
`endif
        output Z1, Z2, CNT
    );
endinterface

// File: rtl/seq_det_grp.sv
// Serial pattern detector with grouped match counter (Z1 per match, Z2 per TARGET matches).
// Optional 16-bit saturating match total enabled by SEQ_DET_GRP_TOTAL_EN.
module seq_det_grp #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 3,
    parameter int               TARGET  = 3
) (
    input  logic         CLK,
    input  logic         RST_N,
    seq_det_grp_if.slave bus
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    // The oldest bit only matters for the compare, so PAT_W-1 bits are kept.
    localparam int HW     = (PAT_W > 1) ? PAT_W - 1 : 1;

    if (PAT_W < 1 || PAT_W > 16) begin : g_bad_pat_w
        $error("seq_det_grp: PAT_W must be in 1..16");
    end
    if (TARGET < 1 || TARGET > (2 ** CNT_W) - 1) begin : g_bad_target
        $error("seq_det_grp: TARGET must be in 1..2^CNT_W-1");
    end

    logic [HW-1:0]     hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              z1_q, z1_d;
    logic              z2_q, z2_d;

    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_n;
    logic              match;

    if (PAT_W == 1) begin : g_w1
        assign hist_n = bus.X;
    end else begin : g_wn
        assign hist_n = {hist_q[PAT_W-2:0], bus.X};
    end

    assign fill_n = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    assign match  = bus.X_VLD && (fill_n == FILL_W'(PAT_W)) && (hist_n == PATTERN);

`ifdef SEQ_DET_GRP_TOTAL_EN
    logic [15:0] total_q, total_d;
`endif

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        z1_d   = 1'b0;
        z2_d   = 1'b0;
`ifdef SEQ_DET_GRP_TOTAL_EN
        total_d = total_q;
`endif
        if (bus.CLR) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
`ifdef SEQ_DET_GRP_TOTAL_EN
            total_d = '0;
`endif
        end else if (bus.X_VLD) begin
            if (match) begin
                z1_d = 1'b1;
                // Non-overlap mode forces a full fresh pattern for the next hit.
                if (OVERLAP) begin
                    hist_d = hist_n[HW-1:0];
                    fill_d = FILL_W'(PAT_W);
                end else begin
                    hist_d = '0;
                    fill_d = '0;
                end
                if (cnt_q == CNT_W'(TARGET - 1)) begin
                    cnt_d = '0;
                    z2_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`ifdef SEQ_DET_GRP_TOTAL_EN
                if (total_q != 16'hFFFF) total_d = total_q + 16'd1;
`endif
            end else begin
                hist_d = hist_n[HW-1:0];
                fill_d = fill_n;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            z1_q   <= 1'b0;
            z2_q   <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            z1_q   <= z1_d;
            z2_q   <= z2_d;
        end
    end

`ifdef SEQ_DET_GRP_TOTAL_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) total_q <= '0;
        else        total_q <= total_d;
    end
    assign bus.TOTAL = total_q;
`endif

    assign bus.Z1  = z1_q;
    assign bus.Z2  = z2_q;
    assign bus.CNT = cnt_q;
endmodule
